// File: rtl/ex_mdu_pkg.sv
// Shared execute-stage defines: instruction opcodes, MDU op and state encodings,
// special-case constants and small op-classification helpers.
package ex_mdu_pkg;

    localparam logic [6:0] INST_TYPE_R_M    = 7'b0110011;
    localparam logic [6:0] INST_TYPE_R_M_W  = 7'b0111011;
    localparam logic [6:0] INST_FUNCT7_MDU  = 7'b0000001;

    typedef enum logic [3:0] {
        MDU_MUL    = 4'd0,
        MDU_MULH   = 4'd1,
        MDU_MULHSU = 4'd2,
        MDU_MULHU  = 4'd3,
        MDU_DIV    = 4'd4,
        MDU_DIVU   = 4'd5,
        MDU_REM    = 4'd6,
        MDU_REMU   = 4'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam int MDU_CNT_W  = 7;
    localparam int MDU_WORD_W = 32;

    typedef struct packed {
        mdu_op_e op;
        logic    word;
        logic    neg_q;   // also the product sign for multiplies
        logic    neg_r;
    } mdu_req_t;

    function automatic logic mdu_op_is_mul(logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

    function automatic logic mdu_op_is_mulh(logic [3:0] op);
        return (op[3:2] == 2'b00) && (op[1:0] != 2'b00);
    endfunction

    function automatic logic mdu_op_is_rem(logic [3:0] op);
        return op[3:1] == 3'b011;
    endfunction

    // W-variant of a high-half multiply does not exist and is treated as reserved
    function automatic logic mdu_op_valid(logic [3:0] op, logic word);
        return !op[3] && !(word && mdu_op_is_mulh(op));
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath, one quotient bit per cycle, plus the shared
// iteration counter. Operands arrive as magnitudes; divisor is never zero here.
module mdu_div_core
    import ex_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            cnt_zero,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [MDU_CNT_W-1:0] cnt;
    logic [XLEN-1:0]      dvd;   // dividend bits shift out the top, quotient bits shift in
    logic [XLEN-1:0]      rem;
    logic [XLEN-1:0]      dsr;
    logic [XLEN:0]        rem_sh;
    logic                 ge;

    always_comb begin
        rem_sh  = {rem, dvd[XLEN-1]};
        ge      = rem_sh >= {1'b0, dsr};
        quo_nxt = {dvd[XLEN-2:0], ge};
        rem_nxt = ge ? XLEN'(rem_sh - {1'b0, dsr}) : rem_sh[XLEN-1:0];
    end

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            dvd <= '0;
            rem <= '0;
            dsr <= '0;
        end else if (load) begin
            // word dividends are left-aligned so the first bit taken is bit 31
            cnt <= word ? MDU_CNT_W'(MDU_WORD_W - 1) : MDU_CNT_W'(XLEN - 1);
            dvd <= word ? (dividend << MDU_WORD_W) : dividend;
            rem <= '0;
            dsr <= divisor;
        end else if (step) begin
            dvd <= quo_nxt;
            rem <= rem_nxt;
            if (!cnt_zero)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit: IDLE/CALC/DONE FSM, shift-add multiplier,
// sign fixup and special cases. EX_MDU_FAST_MUL_EN selects a one-cycle multiplier.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic              word_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              flush_i,
    input  logic              ex_stall,
    output logic              busy_o,
    output logic              ex_stall_req,
    output logic              res_valid_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic [ADDR_W-1:0] rd_addr_o
);

    localparam int PW = 2 * XLEN;

    mdu_state_e      state, state_nxt;
    mdu_req_t        req;
    logic            eff_word, op_ok, s1, s2, is_mul, is_rem;
    logic [XLEN-1:0] a, b, a_mag, b_mag, min_neg;
    logic            a_neg, b_neg, div0, ovf, special, fast;
    logic [XLEN-1:0] spec_raw, spec_res, fast_res, calc_res;
    logic [PW-1:0]   prod, prod_nxt, mul_p;
    logic [XLEN-1:0] mcand;
    logic [XLEN:0]   psum;
    logic            load, step, cnt_zero;
    logic [XLEN-1:0] quo_nxt, rem_nxt;

    function automatic logic [XLEN-1:0] ext32(logic [XLEN-1:0] v, logic sgn);
        return sgn ? XLEN'($signed(v[31:0])) : XLEN'(v[31:0]);
    endfunction

    function automatic logic [XLEN-1:0] mul_result(logic high, logic word, logic neg,
                                                    logic [PW-1:0] p);
        logic [PW-1:0]   ps;
        logic [XLEN-1:0] r;
        ps = neg ? -p : p;
        r  = high ? ps[PW-1:XLEN] : ps[XLEN-1:0];
        return word ? ext32(r, 1'b1) : r;
    endfunction

    function automatic logic [XLEN-1:0] div_result(logic rem_sel, logic word, logic neg_q,
                                                    logic neg_r, logic [XLEN-1:0] q,
                                                    logic [XLEN-1:0] r);
        logic [XLEN-1:0] v;
        v = rem_sel ? (neg_r ? -r : r) : (neg_q ? -q : q);
        return word ? ext32(v, 1'b1) : v;
    endfunction

    // Issue-side decode straight from the request inputs
    always_comb begin
        eff_word = (XLEN == 64) && word_i;
        op_ok    = mdu_op_valid(op_i, eff_word);
        is_mul   = mdu_op_is_mul(op_i);
        is_rem   = mdu_op_is_rem(op_i);
        s1       = (op_i == MDU_MULH) || (op_i == MDU_MULHSU) || (op_i == MDU_DIV) || (op_i == MDU_REM);
        s2       = (op_i == MDU_MULH) || (op_i == MDU_DIV) || (op_i == MDU_REM);
        a        = eff_word ? ext32(op1_i, s1) : op1_i;
        b        = eff_word ? ext32(op2_i, s2) : op2_i;
        a_neg    = s1 && a[XLEN-1];
        b_neg    = s2 && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        min_neg  = eff_word ? ext32(XLEN'(32'h8000_0000), 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        div0     = !is_mul && (b == '0);
        ovf      = !is_mul && s2 && (a == min_neg) && (b == '1);
        special  = div0 || ovf;
        if (div0)
            spec_raw = is_rem ? a : '1;
        else
            spec_raw = is_rem ? '0 : a;
        spec_res = eff_word ? ext32(spec_raw, 1'b1) : spec_raw;
`ifdef EX_MDU_FAST_MUL_EN
        fast     = is_mul;
        fast_res = mul_result(op_i[1:0] != 2'b00, eff_word, a_neg ^ b_neg,
                              PW'(a_mag) * PW'(b_mag));
`else
        fast     = 1'b0;
        fast_res = '0;
`endif
    end

    // One shift-add step: low half holds the unconsumed multiplier bits
    always_comb begin
        psum     = {1'b0, prod[PW-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {psum, prod[XLEN-1:1]};
        mul_p    = req.word ? (prod_nxt >> (XLEN - MDU_WORD_W)) : prod_nxt;
        if (mdu_op_is_mul(req.op))
            calc_res = mul_result(req.op != MDU_MUL, req.word, req.neg_q, mul_p);
        else
            calc_res = div_result(mdu_op_is_rem(req.op), req.word, req.neg_q, req.neg_r,
                                  quo_nxt, rem_nxt);
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (start_i && !flush_i && op_ok) begin
                    load      = 1'b1;
                    state_nxt = (special || fast) ? MDU_DONE : MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (flush_i) begin
                    state_nxt = MDU_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_zero)
                        state_nxt = MDU_DONE;
                end
            end
            MDU_DONE: begin
                if (flush_i || !ex_stall)
                    state_nxt = MDU_IDLE;
            end
            default: state_nxt = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MDU_IDLE;
            req       <= '0;
            prod      <= '0;
            mcand     <= '0;
            rd_data_o <= '0;
            rd_addr_o <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                req.op    <= mdu_op_e'(op_i);
                req.word  <= eff_word;
                req.neg_q <= a_neg ^ b_neg;
                req.neg_r <= a_neg;
                rd_addr_o <= rd_addr_i;
                prod      <= {{XLEN{1'b0}}, b_mag};
                mcand     <= a_mag;
                if (special || fast)
                    rd_data_o <= special ? spec_res : fast_res;
            end
            if (step) begin
                prod <= prod_nxt;
                // sign fixup lands together with the last iteration
                if (cnt_zero)
                    rd_data_o <= calc_res;
            end
        end
    end

    mdu_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .word     (eff_word),
        .dividend (a_mag),
        .divisor  (b_mag),
        .cnt_zero (cnt_zero),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    assign busy_o       = (state != MDU_IDLE);
    assign res_valid_o  = (state == MDU_DONE);
    assign ex_stall_req = (start_i && (state == MDU_IDLE) && op_ok) || (state == MDU_CALC);

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu (XLEN=64): directed corner cases plus random
// operations against an arithmetic reference model.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, word_i, flush_i, ex_stall;
    logic [3:0]  op_i;
    logic [63:0] op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o, ex_stall_req, res_valid_o;
    logic [63:0] rd_data_o;
    logic [4:0]  rd_addr_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(64), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .op_i         (op_i),
        .word_i       (word_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .rd_addr_i    (rd_addr_i),
        .flush_i      (flush_i),
        .ex_stall     (ex_stall),
        .busy_o       (busy_o),
        .ex_stall_req (ex_stall_req),
        .res_valid_o  (res_valid_o),
        .rd_data_o    (rd_data_o),
        .rd_addr_o    (rd_addr_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // RISC-V M-extension semantics computed directly
    function automatic logic [63:0] ref_model(input logic [3:0] op, input bit w,
                                              input logic [63:0] x, input logic [63:0] y);
        longint      sa, sb;
        int          sa32, sb32;
        logic [127:0] xe, ye, p;
        logic [31:0] r32;
        logic [63:0] r;
        bit          ov32;
        r = '0; r32 = '0;
        sa = x; sb = y; sa32 = x[31:0]; sb32 = y[31:0];
        ov32 = (sa32 == 32'sh8000_0000) && (sb32 == -1);
        if (w) begin
            case (op)
                4'd0: r32 = x[31:0] * y[31:0];
                4'd4: if (sb32 == 0) r32 = '1; else if (ov32) r32 = x[31:0]; else r32 = sa32 / sb32;
                4'd5: if (y[31:0] == 0) r32 = '1; else r32 = x[31:0] / y[31:0];
                4'd6: if (sb32 == 0) r32 = x[31:0]; else if (ov32) r32 = '0; else r32 = sa32 % sb32;
                4'd7: if (y[31:0] == 0) r32 = x[31:0]; else r32 = x[31:0] % y[31:0];
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (op)
                4'd0: r = x * y;
                4'd1, 4'd2, 4'd3: begin
                    xe = (op != 4'd3) ? {{64{x[63]}}, x} : {64'b0, x};
                    ye = (op == 4'd1) ? {{64{y[63]}}, y} : {64'b0, y};
                    p  = xe * ye;
                    r  = p[127:64];
                end
                4'd4: if (y == 0) r = '1; else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x; else r = sa / sb;
                4'd5: if (y == 0) r = '1; else r = x / y;
                4'd6: if (y == 0) r = x; else if (x == 64'h8000_0000_0000_0000 && y == '1) r = '0; else r = sa % sb;
                4'd7: if (y == 0) r = x; else r = x % y;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input bit w,
                                       input logic [63:0] x, input logic [63:0] y);
        bit is_div, z, ov;
        is_div = op >= 4'd4;
        z  = w ? (y[31:0] == 0) : (y == 0);
        ov = (op == 4'd4 || op == 4'd6) &&
             (w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                : (x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF));
        if (is_div && (z || ov)) return 1;
`ifdef EX_MDU_FAST_MUL_EN
        if (!is_div) return 1;
`endif
        return w ? 33 : 65;
    endfunction

    // Issues one op once the unit is idle; returns at #1 after the edge showing DONE
    task automatic run_op(input logic [3:0] op, input bit w, input logic [63:0] x,
                          input logic [63:0] y, input string tag);
        logic [63:0] exp_d;
        logic [4:0]  rd;
        int          lat, exp_l;
        exp_d = ref_model(op, w, x, y);
        exp_l = ref_latency(op, w, x, y);
        rd    = 5'($urandom_range(1, 31));
        lat   = 0;
        while (busy_o && lat < 200) begin @(posedge clk); #1; lat++; end
        start_i = 1'b1; op_i = op; word_i = w; op1_i = x; op2_i = y; rd_addr_i = rd;
        #1 chk({tag, "_streq_issue"}, 64'(ex_stall_req), 64'd1);
        @(posedge clk); #1;
        start_i = 1'b0; op1_i = ~x; op2_i = ~y; rd_addr_i = ~rd; op_i = 4'($urandom_range(0, 15));
        lat = 1;
        if (exp_l > 1) chk({tag, "_streq_calc"}, 64'(ex_stall_req), 64'd1);
        while (!res_valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_l));
        chk({tag, "_data"}, rd_data_o, exp_d);
        chk({tag, "_rd"}, 64'(rd_addr_o), 64'(rd));
        chk({tag, "_streq_done"}, 64'(ex_stall_req), 64'd0);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 6))
            0: v = '0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'($urandom_range(0, 20));
            4: v = {32'($urandom()), 32'h8000_0000};
            5: v = -64'($urandom_range(1, 20));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] x, y, e;
        logic [3:0]  op;
        bit          w;

        rst = 1'b1; start_i = 0; word_i = 0; flush_i = 0; ex_stall = 0;
        op_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
        #12;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_streq", 64'(ex_stall_req), 64'd0);
        chk("rst_valid", 64'(res_valid_o), 64'd0);
        chk("rst_data", rd_data_o, 64'd0);
        chk("rst_rd", 64'(rd_addr_o), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_op(4'd4, 0, -64'sd7, 64'd2, "div_m7_2");
        run_op(4'd6, 0, -64'sd7, 64'd2, "rem_m7_2");
        run_op(4'd5, 0, 64'h1234, 64'd0, "divu_by0");
        run_op(4'd7, 0, 64'h1234, 64'd0, "remu_by0");
        run_op(4'd4, 0, 64'h8000_0000_0000_0000, '1, "div_ovf");
        run_op(4'd4, 1, 64'h8000_0000, '1, "divw_ovf");
        run_op(4'd3, 0, '1, '1, "mulhu_max");
        run_op(4'd0, 1, 64'h7FFF_FFFF, 64'd2, "mulw");
        run_op(4'd2, 0, -64'sd3, '1, "mulhsu");
        run_op(4'd1, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "mulh_min");

        // reserved op and MULH-word are ignored; start under flush is dropped
        @(posedge clk); #1;
        start_i = 1; op_i = 4'd9; word_i = 0;
        #1 chk("rsv_streq", 64'(ex_stall_req), 64'd0);
        @(posedge clk); #1 chk("rsv_busy", 64'(busy_o), 64'd0);
        op_i = 4'd1; word_i = 1;
        @(posedge clk); #1 chk("mulhw_busy", 64'(busy_o), 64'd0);
        op_i = 4'd4; word_i = 0; op2_i = 64'd3; flush_i = 1;
        @(posedge clk); #1 chk("start_flush_busy", 64'(busy_o), 64'd0);
        start_i = 0; flush_i = 0;

        // flush at CALC cycle 10, then start a new op immediately
        start_i = 1; op_i = 4'd5; word_i = 0; op1_i = 64'd1000; op2_i = 64'd7; rd_addr_i = 5'd3;
        @(posedge clk); #1 start_i = 0;
        repeat (9) @(posedge clk);
        #1 chk("flush_calc_busy", 64'(busy_o), 64'd1);
        flush_i = 1;
        @(posedge clk); #1 flush_i = 0;
        chk("flush_valid", 64'(res_valid_o), 64'd0);
        chk("flush_busy", 64'(busy_o), 64'd0);
        run_op(4'd6, 0, 64'd1001, 64'd10, "after_flush");

        // asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        start_i = 1; op_i = 4'd5; word_i = 0; op1_i = 64'd100; op2_i = 64'd7; rd_addr_i = 5'd9;
        @(posedge clk); #1 start_i = 0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(res_valid_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_data", rd_data_o, 64'd0);
        chk("arst_rd", 64'(rd_addr_o), 64'd0);
        chk("arst_streq", 64'(ex_stall_req), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // downstream stall holds the result
        ex_stall = 1;
        x = -64'sd1000; y = 64'd9;
        e = ref_model(4'd4, 0, x, y);
        run_op(4'd4, 0, x, y, "stall_op");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", 64'(res_valid_o), 64'd1);
            chk("stall_data", rd_data_o, e);
        end
        ex_stall = 0;
        @(posedge clk); #1;
        chk("stall_release_valid", 64'(res_valid_o), 64'd0);
        chk("stall_release_busy", 64'(busy_o), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            if (op >= 4'd1 && op <= 4'd3) w = 0;
            x = rnd_operand();
            y = rnd_operand();
            run_op(op, w, x, y, $sformatf("rnd%0d_op%0d_w%0d", i, op, w));
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
